// File: rtl/dma_priority_arbiter.sv
// DMA request arbiter and HRQ/HLDA hold-handshake controller.
// Qualifies raw channel requests, picks a winner by fixed or rotating
// priority, runs the bus-hold handshake with a timeout and drives DACK.
module dma_priority_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = $clog2(NUM_CH),
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] mask,
  input  logic              dreq_sense,
  input  logic              dack_sense,
  input  logic              rotate_pri,
  input  logic              HLDA,
  input  logic              svc_done,
  output logic              hrq,
  output logic [NUM_CH-1:0] DACK,
  output logic              VALID_DACK,
  output logic [CH_W-1:0]   grant_ch,
  output logic              timeout
);

  localparam int unsigned    NCH     = NUM_CH;
  localparam int             CNT_W   = $clog2(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_REQ,
    ACTIVE,
    RELEASE
  } state_t;

  state_t           state, state_n;
  logic             hrq_n, valid_n, timeout_n;
  logic [CH_W-1:0]  grant_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CH_W-1:0]  ptr, ptr_n;

  logic [NUM_CH-1:0] vreq;
  logic [CH_W-1:0]   base, winner;
  logic              any_req;
  int unsigned       idx;

  // Request is live when it matches the sense polarity and is not masked.
  assign vreq = ~(DREQ ^ {NUM_CH{dreq_sense}}) & ~mask;

  // Priority search: scan from the pointer (or ch0 in fixed mode) with wrap.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    base    = rotate_pri ? ptr : '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(base) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!any_req && vreq[idx[CH_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[CH_W-1:0];
      end
    end
  end

  // Next-state and next registered-output logic for the handshake FSM.
  always_comb begin
    state_n   = state;
    hrq_n     = hrq;
    valid_n   = VALID_DACK;
    grant_n   = grant_ch;
    timeout_n = 1'b0;
    cnt_n     = cnt;
    ptr_n     = ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = HOLD_REQ;
          grant_n = winner;
          cnt_n   = '0;
          hrq_n   = 1'b1;
        end
      end
      HOLD_REQ: begin
        // A withdrawn request wins over everything; HLDA wins over timeout.
        if (!vreq[grant_ch]) begin
          state_n = IDLE;
          hrq_n   = 1'b0;
        end else if (HLDA) begin
          state_n = ACTIVE;
          valid_n = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_n   = IDLE;
          hrq_n     = 1'b0;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (!HLDA) begin
          state_n = IDLE;
          hrq_n   = 1'b0;
          valid_n = 1'b0;
        end else if (svc_done) begin
          state_n = RELEASE;
          hrq_n   = 1'b0;
          valid_n = 1'b0;
          if (rotate_pri) ptr_n = (grant_ch == LAST_CH) ? '0 : grant_ch + 1'b1;
        end
      end
      RELEASE: begin
        if (!HLDA) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered-output storage.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      hrq        <= 1'b0;
      VALID_DACK <= 1'b0;
      grant_ch   <= '0;
      timeout    <= 1'b0;
      cnt        <= '0;
      ptr        <= '0;
    end else begin
      state      <= state_n;
      hrq        <= hrq_n;
      VALID_DACK <= valid_n;
      grant_ch   <= grant_n;
      timeout    <= timeout_n;
      cnt        <= cnt_n;
      ptr        <= ptr_n;
    end
  end

  // DACK decode: only the granted channel is active, and only in ACTIVE.
  always_comb begin
    DACK = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      DACK[i] = ~(((state == ACTIVE) && (grant_ch == CH_W'(i))) ^ dack_sense);
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter (4 channels, timeout 64).
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] mask;
  logic       dreq_sense;
  logic       dack_sense;
  logic       rotate_pri;
  logic       HLDA;
  logic       svc_done;
  logic       hrq;
  logic [3:0] DACK;
  logic       VALID_DACK;
  logic [1:0] grant_ch;
  logic       timeout;

  int checks   = 0;
  int failures = 0;
  int n;

  dma_priority_arbiter #(
    .NUM_CH(4),
    .HOLD_TIMEOUT(64)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .DREQ(DREQ),
    .mask(mask),
    .dreq_sense(dreq_sense),
    .dack_sense(dack_sense),
    .rotate_pri(rotate_pri),
    .HLDA(HLDA),
    .svc_done(svc_done),
    .hrq(hrq),
    .DACK(DACK),
    .VALID_DACK(VALID_DACK),
    .grant_ch(grant_ch),
    .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full service from IDLE with a live request: grant, ACTIVE, release.
  task automatic do_service(input logic [1:0] exp_ch, input logic [3:0] exp_dack, input string tag);
    tick();
    check({tag, "_hrq"}, 32'(hrq), 32'd1);
    check({tag, "_grant"}, 32'(grant_ch), 32'(exp_ch));
    HLDA = 1'b1;
    tick();
    check({tag, "_valid"}, 32'(VALID_DACK), 32'd1);
    check({tag, "_dack"}, 32'(DACK), 32'(exp_dack));
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    HLDA     = 1'b0;
    check({tag, "_rel_hrq"}, 32'(hrq), 32'd0);
    check({tag, "_rel_valid"}, 32'(VALID_DACK), 32'd0);
    tick();
  endtask

  initial begin
    RESET      = 1'b0;
    DREQ       = 4'b0000;
    mask       = 4'b0000;
    dreq_sense = 1'b1;
    dack_sense = 1'b1;
    rotate_pri = 1'b0;
    HLDA       = 1'b0;
    svc_done   = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hrq", 32'(hrq), 32'd0);
    check("rst_valid", 32'(VALID_DACK), 32'd0);
    check("rst_dack", 32'(DACK), 32'h0);
    check("rst_grant", 32'(grant_ch), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    RESET = 1'b1;
    tick();

    // Fixed priority: ch1 beats ch2, HLDA three cycles after hrq
    DREQ = 4'b0110;
    tick();
    check("fix_hrq", 32'(hrq), 32'd1);
    check("fix_grant", 32'(grant_ch), 32'd1);
    check("fix_pre_valid", 32'(VALID_DACK), 32'd0);
    tick();
    tick();
    HLDA = 1'b1;
    check("fix_wait_dack", 32'(DACK), 32'h0);
    tick();
    check("fix_valid", 32'(VALID_DACK), 32'd1);
    check("fix_dack", 32'(DACK), 32'h2);
    // Higher-priority ch0 arrives and ch1 drops: grant stays locked
    DREQ = 4'b0001;
    tick();
    check("fix_lock_grant", 32'(grant_ch), 32'd1);
    check("fix_lock_dack", 32'(DACK), 32'h2);
    check("fix_lock_valid", 32'(VALID_DACK), 32'd1);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    check("fix_rel_hrq", 32'(hrq), 32'd0);
    check("fix_rel_valid", 32'(VALID_DACK), 32'd0);
    check("fix_rel_dack", 32'(DACK), 32'h0);
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();

    // Rotating priority with all requests held: 0,1,2,3,0
    rotate_pri = 1'b1;
    DREQ       = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_service(2'(i % 4), 4'(1 << (i % 4)), "rot");
    end
    DREQ = 4'b0000;
    tick();

    // Timeout: ch2 requests, HLDA never comes
    rotate_pri = 1'b0;
    DREQ       = 4'b0100;
    tick();
    check("to_hrq", 32'(hrq), 32'd1);
    check("to_grant", 32'(grant_ch), 32'd2);
    n = 0;
    while (!timeout && n < 100) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd64);
    check("to_hrq_drop", 32'(hrq), 32'd0);
    check("to_dack", 32'(DACK), 32'h0);
    DREQ = 4'b0000;
    tick();
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_idle_hrq", 32'(hrq), 32'd0);

    // Polarity and mask: active-low DREQ/DACK, only ch2 qualifies
    DREQ       = 4'b1011;
    mask       = 4'b0001;
    dreq_sense = 1'b0;
    dack_sense = 1'b0;
    #1;
    check("pol_idle_dack", 32'(DACK), 32'hF);
    do_service(2'd2, 4'b1011, "pol");
    DREQ       = 4'b0000;
    mask       = 4'b0000;
    dreq_sense = 1'b1;
    dack_sense = 1'b1;
    tick();

    // Abort: pointer is 1 after rotation; ch3 granted, then HLDA drops
    rotate_pri = 1'b1;
    DREQ       = 4'b1000;
    tick();
    check("ab_grant", 32'(grant_ch), 32'd3);
    HLDA = 1'b1;
    tick();
    check("ab_dack", 32'(DACK), 32'h8);
    HLDA = 1'b0;
    tick();
    check("ab_valid", 32'(VALID_DACK), 32'd0);
    check("ab_dack_off", 32'(DACK), 32'h0);
    check("ab_hrq", 32'(hrq), 32'd0);
    // Pointer still 1: ch3 beats ch0 on re-request
    DREQ = 4'b1001;
    tick();
    check("ab_regrant", 32'(grant_ch), 32'd3);
    HLDA = 1'b1;
    tick();
    check("ar_active_valid", 32'(VALID_DACK), 32'd1);

    // Async reset between clock edges while ACTIVE
    #2;
    RESET = 1'b0;
    #1;
    check("ar_hrq", 32'(hrq), 32'd0);
    check("ar_valid", 32'(VALID_DACK), 32'd0);
    check("ar_timeout", 32'(timeout), 32'd0);
    check("ar_dack", 32'(DACK), 32'h0);
    check("ar_grant", 32'(grant_ch), 32'd0);
    #2;
    DREQ  = 4'b0000;
    HLDA  = 1'b0;
    RESET = 1'b1;
    tick();
    check("ar_post_hrq", 32'(hrq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Parametrised N-channel DMA request arbiter and hold-handshake controller; next generation of the fixed 4-channel DREQ/VALID_DACK priority path.
- Qualifies raw DREQ lines (sense polarity, mask), selects a winner by fixed or rotating priority, runs the HRQ/HLDA bus-hold handshake with a timeout, drives per-channel DACK, and tells the timing/control FSM which channel owns the bus.
- Sits between channel request pins / mask register and the timing/control FSM.

Parameters:
- NUM_CH, 4, number of DMA channels (2..8).
- CH_W, $clog2(NUM_CH), channel index width (derived; not overridden).
- HOLD_TIMEOUT, 64, cycles HRQ may wait for HLDA before abandoning the request (>=2).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous active-low reset.
- DREQ  in  NUM_CH  raw channel requests.
- mask  in  NUM_CH  1 = channel masked.
- dreq_sense  in  1  1 = DREQ active-high, 0 = active-low.
- dack_sense  in  1  1 = DACK active-high, 0 = active-low.
- rotate_pri  in  1  0 = fixed priority (ch0 highest), 1 = rotating.
- HLDA  in  1  hold acknowledge from CPU.
- svc_done  in  1  one-cycle pulse from timing/control: service of granted channel finished.
- hrq  out  1  hold request to CPU.
- DACK  out  NUM_CH  per-channel acknowledge, polarity per dack_sense.
- VALID_DACK  out  1  active-high: a channel is acknowledged.
- grant_ch  out  CH_W  index of granted/pending channel.
- timeout  out  1  one-cycle pulse: HLDA not received within HOLD_TIMEOUT.

Behaviour:
- Qualified request: vreq[i] = (DREQ[i] == dreq_sense) & ~mask[i]; combinational.
- Reset (RESET=0, async): state IDLE, hrq=0, VALID_DACK=0, DACK all = ~dack_sense, grant_ch=0, timeout=0, hold counter=0, priority pointer=0 (ch0 highest).
- States: IDLE, HOLD_REQ, ACTIVE, RELEASE; all outputs registered, except DACK, which is decoded from registered state and grant_ch XORed with dack_sense.
- IDLE: if any vreq, latch winner into grant_ch, clear counter, go HOLD_REQ; hrq=1 from the next cycle (one-cycle DREQ->HRQ latency).
- HOLD_REQ:
  - If HLDA=1 and vreq[grant_ch]=1: go ACTIVE; DACK[grant_ch] and VALID_DACK asserted the next cycle.
  - If vreq[grant_ch] drops before HLDA: go IDLE, hrq=0; no timeout.
  - If counter reaches HOLD_TIMEOUT-1 without HLDA: timeout pulse for one cycle, go IDLE, hrq=0.
  - Precedence: HLDA beats timeout when both occur in the same cycle.
- ACTIVE:
  - hrq=1, VALID_DACK=1, DACK[grant_ch] active, all other DACK inactive.
  - Winner is locked; new higher-priority requests are ignored until release.
  - DREQ deassert does not end service; only svc_done does.
  - On svc_done: go RELEASE.
  - If HLDA drops while ACTIVE: abort to IDLE; hrq, VALID_DACK and DACK deassert the next cycle; priority pointer unchanged.
- RELEASE:
  - hrq=0, VALID_DACK=0, DACK inactive.
  - On entry, if rotate_pri=1, pointer <= (grant_ch+1) mod NUM_CH, so the serviced channel becomes lowest priority.
  - Stay until HLDA=0, then IDLE. A new request cannot raise hrq earlier than one cycle after HLDA low.
- Priority search:
  - Fixed mode: lowest index among vreq wins.
  - Rotating mode: first vreq found scanning pointer, pointer+1, … with wrap at NUM_CH-1 -> 0.
  - Toggling rotate_pri takes effect at the next IDLE arbitration; pointer retained.
- Mask or sense changes during ACTIVE do not affect the current grant.
- Counter saturates; never wraps.

Test Plan:
- Fixed priority: DREQ=4'b0110 active-high, no mask, HLDA after 3 cycles -> hrq 1 cycle after DREQ; grant_ch=1, DACK=4'b0010, VALID_DACK=1 one cycle after HLDA; svc_done -> all deassert, hrq=0.
- Rotating: rotate_pri=1, DREQ=4'b1111 held, four services -> grant order 0,1,2,3, then 0 again.
- Timeout: DREQ[2]=1, HLDA held 0, HOLD_TIMEOUT=64 -> timeout pulses exactly 64 cycles after hrq rises; hrq=0 next cycle; no DACK.
- Polarity and mask: dreq_sense=0, dack_sense=0, DREQ=4'b1011, mask=4'b0001 -> only ch2 qualifies; DACK=4'b1011 (ch2 low) during ACTIVE.
- Abort: HLDA drops mid-ACTIVE on ch3 -> VALID_DACK=0, DACK inactive next cycle; rotating pointer unchanged, so ch3 regains the grant on re-request.
- Async reset mid-ACTIVE: RESET low between clock edges -> hrq, VALID_DACK, timeout=0 and DACK inactive immediately; grant_ch=0.
